// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dump sequencer.
//   dump_state_e : FSM state encoding (IDLE / READ / DRAIN / DONE)
//   DEF_ADDR_W   : default register address width (32 registers)
//   DEF_DATA_W   : default register data width
package regfile_dumper_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Read-side sequencer for the register file. Walks an address range on one
// combinational read port and streams {address, data} beats over a
// valid/ready handshake. StallReq is held while the dump is active so the
// core issues no register writes mid-dump.
//
// Ports:
//   clock      in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Start      in   one-cycle start pulse, honoured only in IDLE
//   Abort      in   cancel; wins over every other event
//   FirstAddr  in   first register of the range (sampled on Start)
//   LastAddr   in   last register of the range (sampled on Start)
//   RdAddr     out  register file read address
//   RdData     in   register file read data for RdAddr, same cycle
//   OutValid   out  beat present on OutAddr/OutData
//   OutReady   in   sink accepts the beat when OutValid & OutReady
//   OutAddr    out  register index of the current beat
//   OutData    out  register contents of the current beat
//   Busy       out  high in READ or DRAIN
//   StallReq   out  same as Busy
//   Done       out  one-cycle pulse after the last beat is accepted
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start
// READ  | issuing reads, loading the output slice whenever it is free
// DRAIN | final beat loaded, waiting for the sink to take it
// DONE  | one-cycle Done pulse, then back to IDLE
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddr,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              StallReq,
  output logic              Done
);

  // One extra bit so a full 0..NUM_REGS-1 range (count = NUM_REGS) fits.
  localparam int CNT_W = ADDR_W + 1;

  dump_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  remaining_d;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  logic out_fire;
  logic slice_free;

  assign out_fire    = out_valid_q & OutReady;
  assign slice_free  = ~out_valid_q | OutReady;
  // Range length: wrap-around falls out of the modular subtraction.
  assign remaining_d = {1'b0, LastAddr - FirstAddr} + CNT_W'(1);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (Abort) begin
      // ptr is left alone so RdAddr keeps its last value.
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            ptr_q       <= FirstAddr;
            remaining_q <= remaining_d;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (slice_free) begin
            out_addr_q  <= ptr_q;
            out_data_q  <= RdData;
            out_valid_q <= 1'b1;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              // Pointer stays on the last address so RdAddr holds in DRAIN.
              state_q <= ST_DRAIN;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RdAddr   = ptr_q;
  assign OutValid = out_valid_q;
  assign OutAddr  = out_addr_q;
  assign OutData  = out_data_q;
  assign Busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign StallReq = Busy;
  assign Done     = (state_q == ST_DONE);

endmodule
